fetch_sequencer: RTL and testbench

Fetch-address controller in the frontend, between the PC-generation logic and the instruction cache request port, directly upstream of the instruction queue. Owns the next-fetch-address register and keeps at most one I$ request in flight. Sequences boot, sequential fetch, queue-driven replay, redirects and flushes. Stops fetching after a fetch exception until redirected.

---
 rtl/fetch_sequencer.sv | 156 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Fetch-address controller between PC generation and the I$ request port.
//   Owns the next-fetch address (npc_q). At most one I$ request is in
//   flight at any time. It sequences boot, sequential fetch, queue replay,
//   redirects and flushes. After a fetch exception it stops until it is
//   redirected or flushed.
//
// Optional feature:
//   FETCH_SEQUENCER_PERF_EN adds 16-bit saturating counters perf_replay_o
//   (accepted replays) and perf_kill_o (cycles with icache_kill_o high).
//
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   boot_addr_i           boot address, sampled in BOOT
//   flush_i               kill everything in flight
//   redirect_valid_i/addr load new fetch address
//   halt_i                block issue of new requests
//   queue_ready_i         instruction queue can take a block
//   replay_i/addr         refetch request from the queue on a response
//   icache_req_*          registered request (valid/addr) plus ready
//   icache_kill_o         drop in-flight/accepted request
//   icache_rsp_valid_i/ex I$ response and its exception flag
//   rsp_valid_o           qualified response to the instruction queue
//   busy_o                request in flight
module fetch_sequencer #(
  parameter int unsigned VLEN             = 39,
  parameter int unsigned FETCH_ALIGN_BITS = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [VLEN-1:0] boot_addr_i,
  input  logic            flush_i,
  input  logic            redirect_valid_i,
  input  logic [VLEN-1:0] redirect_addr_i,
  input  logic            halt_i,
  input  logic            queue_ready_i,
  input  logic            replay_i,
  input  logic [VLEN-1:0] replay_addr_i,
  output logic            icache_req_valid_o,
  output logic [VLEN-1:0] icache_req_addr_o,
  input  logic            icache_req_ready_i,
  output logic            icache_kill_o,
  input  logic            icache_rsp_valid_i,
  input  logic            icache_rsp_ex_i,
  output logic            rsp_valid_o,
`ifdef FETCH_SEQUENCER_PERF_EN
  output logic [15:0]     perf_replay_o,
  output logic [15:0]     perf_kill_o,
`endif
  output logic            busy_o
);

  localparam logic [2:0] BOOT  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] STALL = 3'd3;
  localparam logic [2:0] EXC   = 3'd4;

  localparam int unsigned BLK_W = VLEN - FETCH_ALIGN_BITS;

  logic [2:0]       state_q, state_d;
  logic [VLEN-1:0]  npc_q, npc_d;
  logic             req_valid_q;
  logic             ev, go, rsp_ok;
  logic [BLK_W-1:0] blk_nxt;
  logic [VLEN-1:0]  seq_addr;

  assign ev = flush_i | redirect_valid_i;
  assign go = queue_ready_i & ~halt_i;

  // Next block address: drop the offset inside the block and step one block.
  // The block-index add is exactly BLK_W bits wide, so the top wraps to 0.
  assign blk_nxt  = npc_q[VLEN-1:FETCH_ALIGN_BITS] + {{(BLK_W-1){1'b0}}, 1'b1};
  assign seq_addr = {blk_nxt, {FETCH_ALIGN_BITS{1'b0}}};

  // A response is only forwarded if no redirect/flush happens in the same
  // cycle. This is why a killed request never reaches the queue.
  assign rsp_ok        = (state_q == WAIT) & icache_rsp_valid_i & ~ev;
  assign rsp_valid_o   = rsp_ok;
  assign icache_kill_o = ev & ((state_q == WAIT) |
                               ((state_q == FETCH) & icache_req_ready_i));

  always_comb begin
    state_d = state_q;
    npc_d   = npc_q;
    if (ev) begin
      if (redirect_valid_i) npc_d = redirect_addr_i;
      state_d = go ? FETCH : STALL;
    end else begin
      case (state_q)
        BOOT: begin
          npc_d   = boot_addr_i;
          state_d = go ? FETCH : STALL;
        end
        // Once raised, the request is held until the I$ accepts it.
        // Back-pressure and halt do not withdraw it.
        FETCH: if (icache_req_ready_i) state_d = WAIT;
        STALL: if (go) state_d = FETCH;
        WAIT: begin
          if (icache_rsp_valid_i) begin
            if (icache_rsp_ex_i) begin
              state_d = EXC;
            end else begin
              npc_d   = replay_i ? replay_addr_i : seq_addr;
              state_d = go ? FETCH : STALL;
            end
          end
        end
        EXC:     state_d = EXC;
        default: state_d = BOOT;
      endcase
    end
  end

  // The request valid has its own flop so the bus sees no decode glitches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= BOOT;
      npc_q       <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      npc_q       <= npc_d;
      req_valid_q <= (state_d == FETCH);
    end
  end

  assign icache_req_valid_o = req_valid_q;
  assign icache_req_addr_o  = npc_q;
  assign busy_o             = (state_q == WAIT);

`ifdef FETCH_SEQUENCER_PERF_EN
  // Replays count only when a response is forwarded without an exception,
  // because that is the only case where replay_addr_i is used.
  logic [15:0] perf_replay_q, perf_kill_q;
  logic        replay_acc;

  assign replay_acc = rsp_ok & ~icache_rsp_ex_i & replay_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_replay_q <= '0;
      perf_kill_q   <= '0;
    end else begin
      if (replay_acc && perf_replay_q != 16'hFFFF)
        perf_replay_q <= perf_replay_q + 16'd1;
      if (icache_kill_o && perf_kill_q != 16'hFFFF)
        perf_kill_q <= perf_kill_q + 16'd1;
    end
  end

  assign perf_replay_o = perf_replay_q;
  assign perf_kill_o   = perf_kill_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Inputs change 1 time unit after the
// rising edge. Outputs are sampled 1 time unit later, which is well away
// from the active edge.
module tb_fetch_sequencer;
  localparam int VLEN = 39;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [VLEN-1:0] boot_addr_i;
  logic            flush_i, redirect_valid_i, halt_i, queue_ready_i, replay_i;
  logic [VLEN-1:0] redirect_addr_i, replay_addr_i;
  logic            icache_req_valid_o, icache_req_ready_i, icache_kill_o;
  logic [VLEN-1:0] icache_req_addr_o;
  logic            icache_rsp_valid_i, icache_rsp_ex_i, rsp_valid_o, busy_o;
`ifdef FETCH_SEQUENCER_PERF_EN
  logic [15:0]     perf_replay_o, perf_kill_o;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  fetch_sequencer #(.VLEN(VLEN), .FETCH_ALIGN_BITS(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .boot_addr_i(boot_addr_i),
    .flush_i(flush_i), .redirect_valid_i(redirect_valid_i),
    .redirect_addr_i(redirect_addr_i), .halt_i(halt_i),
    .queue_ready_i(queue_ready_i), .replay_i(replay_i),
    .replay_addr_i(replay_addr_i), .icache_req_valid_o(icache_req_valid_o),
    .icache_req_addr_o(icache_req_addr_o),
    .icache_req_ready_i(icache_req_ready_i), .icache_kill_o(icache_kill_o),
    .icache_rsp_valid_i(icache_rsp_valid_i), .icache_rsp_ex_i(icache_rsp_ex_i),
    .rsp_valid_o(rsp_valid_o),
`ifdef FETCH_SEQUENCER_PERF_EN
    .perf_replay_o(perf_replay_o), .perf_kill_o(perf_kill_o),
`endif
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Request must be valid at the expected address. Accept it and go to WAIT.
  task automatic expect_req_accept(input string tag, input logic [VLEN-1:0] a);
    #1;
    chk({tag, "_valid"}, 64'(icache_req_valid_o), 64'd1);
    chk({tag, "_addr"},  64'(icache_req_addr_o), 64'(a));
    icache_req_ready_i = 1'b1;
    tick();
    icache_req_ready_i = 1'b0;
    #1;
    chk({tag, "_busy"}, 64'(busy_o), 64'd1);
  endtask

  // Present one response in WAIT. The bench checks that it is forwarded.
  task automatic respond(input string tag, input logic ex, input logic rp,
                         input logic [VLEN-1:0] ra);
    icache_rsp_valid_i = 1'b1;
    icache_rsp_ex_i    = ex;
    replay_i           = rp;
    replay_addr_i      = ra;
    #1;
    chk({tag, "_rspv"}, 64'(rsp_valid_o), 64'd1);
    tick();
    icache_rsp_valid_i = 1'b0;
    icache_rsp_ex_i    = 1'b0;
    replay_i           = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; boot_addr_i = 39'h80000004;
    flush_i = 0; redirect_valid_i = 0; redirect_addr_i = '0;
    halt_i = 0; queue_ready_i = 1; replay_i = 0; replay_addr_i = '0;
    icache_req_ready_i = 0; icache_rsp_valid_i = 0; icache_rsp_ex_i = 0;

    // Reset state
    tick(); tick();
    chk("rst_valid", 64'(icache_req_valid_o), 64'd0);
    chk("rst_addr",  64'(icache_req_addr_o), 64'd0);
    chk("rst_busy",  64'(busy_o), 64'd0);
    chk("rst_kill",  64'(icache_kill_o), 64'd0);
    chk("rst_rspv",  64'(rsp_valid_o), 64'd0);
    rst_ni = 1'b1;

    // Boot and sequential fetch. Each request comes 2 cycles after the last.
    tick();
    expect_req_accept("boot0", 39'h80000004);
    respond("boot0", 0, 0, '0);
    expect_req_accept("seq1", 39'h80000008);
    respond("seq1", 0, 0, '0);
    #1 chk("seq2_addr", 64'(icache_req_addr_o), 64'h80000010);

    // Redirect while FETCH is not accepted: no kill is raised.
    redirect_valid_i = 1; redirect_addr_i = 39'h1000;
    #1 chk("redir_fetch_kill", 64'(icache_kill_o), 64'd0);
    tick(); redirect_valid_i = 0;

    // Replay sends the next request to replay_addr. After that, fetch
    // continues sequentially.
    expect_req_accept("rp0", 39'h1000);
    respond("rp0", 0, 1, 39'h1006);
    expect_req_accept("rp1", 39'h1006);
    respond("rp1", 0, 0, '0);

    // Kill in WAIT: a redirect in the same cycle as the response.
    expect_req_accept("kw", 39'h1008);
    icache_rsp_valid_i = 1; redirect_valid_i = 1; redirect_addr_i = 39'h2000;
    #1;
    chk("kw_rspv", 64'(rsp_valid_o), 64'd0);
    chk("kw_kill", 64'(icache_kill_o), 64'd1);
    tick(); icache_rsp_valid_i = 0; redirect_valid_i = 0;

    // Flush in the cycle FETCH is accepted: kill is raised and npc keeps its value.
    #1;
    icache_req_ready_i = 1; flush_i = 1;
    #1 chk("kf_kill", 64'(icache_kill_o), 64'd1);
    tick(); icache_req_ready_i = 0; flush_i = 0;

    // Back-pressure: the response goes to STALL. A stray replay is ignored there.
    expect_req_accept("bp", 39'h2000);
    queue_ready_i = 0;
    respond("bp", 0, 0, '0);
    replay_i = 1; replay_addr_i = 39'h5000;
    #1;
    chk("bp_valid", 64'(icache_req_valid_o), 64'd0);
    chk("bp_busy",  64'(busy_o), 64'd0);
    tick();
    chk("bp_valid2", 64'(icache_req_valid_o), 64'd0);
    replay_i = 0; queue_ready_i = 1;
    tick();

    // Exception response: it is forwarded, then fetch stays quiet until redirect.
    expect_req_accept("ex", 39'h2008);
    respond("ex", 1, 0, '0);
    for (int i = 0; i < 20; i++) begin
      chk("ex_quiet", 64'(icache_req_valid_o), 64'd0);
      tick();
    end
    flush_i = 1; redirect_valid_i = 1; redirect_addr_i = 39'h3000;
    #1 chk("ex_kill", 64'(icache_kill_o), 64'd0);
    tick(); flush_i = 0; redirect_valid_i = 0;
    #1;
    chk("ex_resume_valid", 64'(icache_req_valid_o), 64'd1);
    chk("ex_resume_addr",  64'(icache_req_addr_o), 64'h3000);

    // Wrap at the top of the address space. Valid and address must stay
    // stable while back-pressure and halt toggle.
    redirect_valid_i = 1; redirect_addr_i = 39'h7FFFFFFFF8;
    tick(); redirect_valid_i = 0;
    for (int i = 0; i < 6; i++) begin
      halt_i = i[0]; queue_ready_i = ~i[1];
      #1;
      chk("hold_valid", 64'(icache_req_valid_o), 64'd1);
      chk("hold_addr",  64'(icache_req_addr_o), 64'h7FFFFFFFF8);
      tick();
    end
    halt_i = 0; queue_ready_i = 1;
    expect_req_accept("wrap", 39'h7FFFFFFFF8);
    respond("wrap", 0, 0, '0);
    #1;
    chk("wrap_valid", 64'(icache_req_valid_o), 64'd1);
    chk("wrap_addr",  64'(icache_req_addr_o), 64'h0);

    // Asynchronous reset in mid-operation: valid drops without waiting for an edge.
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", 64'(icache_req_valid_o), 64'd0);
    chk("arst_addr",  64'(icache_req_addr_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
